// File: rtl/vme_bus_requester.sv
// -----------------------------------------------------------------------------
// vme_bus_requester
//
// VME bus requester for the k30p VME interface. Requests the bus on one
// configurable BR level, forwards the bus-grant daisy chain on every level,
// drives BBSY once granted and reports ownership to vme_data_transfer only
// after the previous master has released AS. Release is either
// release-when-done (RWD) or release-on-request (ROR); BCLR forces a release
// at the next idle point. A request that sees no grant within GRANT_TIMEOUT
// cycles is abandoned with a one-cycle bus_timeout pulse.
//
// Ports (all VME-side signals and handshakes are active-low unless noted):
//   clock             system clock
//   reset             asynchronous reset, active-high
//   request_vme       CPU wants the VME bus
//   transfer_busy     vme_data_transfer is mid-cycle
//   bus_acquired      bus owned and AS free
//   bus_timeout       active-high one-cycle pulse on grant timeout
//   vme_br_in         sampled BR lines (wired-OR bus)
//   vme_bus_request   BR drivers
//   vme_bus_grant_in  BGxIN
//   vme_bus_grant_out BGxOUT
//   vme_bbsy_in       sampled BBSY (not needed by this arbitration scheme)
//   vme_bbsy_out      BBSY driver
//   vme_bclr_in       bus clear from the arbiter
//   vme_as_in         sampled AS
// -----------------------------------------------------------------------------
module vme_bus_requester #(
  parameter int NUM_LEVELS      = 4,
  parameter int REQUEST_LEVEL   = 3,
  parameter int RELEASE_MODE    = 0,
  parameter int GRANT_TIMEOUT   = 1023,
  parameter int BBSY_MIN_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  request_vme,
  input  logic                  transfer_busy,
  output logic                  bus_acquired,
  output logic                  bus_timeout,
  input  logic [NUM_LEVELS-1:0] vme_br_in,
  output logic [NUM_LEVELS-1:0] vme_bus_request,
  input  logic [NUM_LEVELS-1:0] vme_bus_grant_in,
  output logic [NUM_LEVELS-1:0] vme_bus_grant_out,
  input  logic                  vme_bbsy_in,
  output logic                  vme_bbsy_out,
  input  logic                  vme_bclr_in,
  input  logic                  vme_as_in
);

  localparam int CNT_W  = (GRANT_TIMEOUT < 1) ? 1 : $clog2(GRANT_TIMEOUT + 1);
  localparam int HOLD_W = (BBSY_MIN_CYCLES < 1) ? 1 : $clog2(BBSY_MIN_CYCLES + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(GRANT_TIMEOUT);
  localparam logic [HOLD_W-1:0] HOLD_MIN    = HOLD_W'(BBSY_MIN_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_WAIT_AS = 3'd2,
    S_OWNER   = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_LEVELS-1:0]   br_q, br_d;
  logic [NUM_LEVELS-1:0]   bg_q, bg_d;
  logic                    bbsy_q, bbsy_d;
  logic                    acq_q, acq_d;
  logic                    timeout_q, timeout_d;
  logic [CNT_W-1:0]        tcnt_q, tcnt_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    pass_q, pass_d;
  logic                    br_req_d;
  logic                    grant_own;
  logic                    other_br;
  logic                    mode_ok;
  logic                    release_ok;
  logic [HOLD_W-1:0]       hold_inc;

  // BBSY readback is part of the bus interface but arbitration here relies on
  // the grant chain and AS only.
  logic unused_bbsy_in;
  assign unused_bbsy_in = vme_bbsy_in;

  assign grant_own = vme_bus_grant_in[REQUEST_LEVEL];
  // Our own BR is always inactive while we own the bus, so any active BR line
  // belongs to another requester.
  assign other_br  = ~&vme_br_in;
  assign mode_ok   = request_vme && ((RELEASE_MODE == 0) || other_br);
  // BCLR only forces release once the current transfer is finished.
  assign release_ok = (hold_q >= HOLD_MIN) && transfer_busy && (!vme_bclr_in || mode_ok);
  assign hold_inc   = (hold_q == HOLD_MIN) ? hold_q : hold_q + 1'b1;

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    hold_d    = hold_q;
    br_req_d  = br_q[REQUEST_LEVEL];
    bbsy_d    = bbsy_q;
    acq_d     = acq_q;
    timeout_d = 1'b0;

    // A grant arriving while we are not requesting belongs downstream; the
    // flag keeps it passed on until the arbiter withdraws it.
    if (grant_own)
      pass_d = 1'b0;
    else if (state_q == S_IDLE)
      pass_d = 1'b1;
    else
      pass_d = pass_q;

    case (state_q)
      S_IDLE: begin
        br_req_d = 1'b1;
        bbsy_d   = 1'b1;
        acq_d    = 1'b1;
        if (!request_vme && !pass_d) begin
          br_req_d = 1'b0;
          tcnt_d   = '0;
          state_d  = S_REQUEST;
        end
      end
      S_REQUEST: begin
        br_req_d = 1'b0;
        tcnt_d   = tcnt_q + 1'b1;
        // Grant has priority over both withdrawal and timeout.
        if (!grant_own) begin
          bbsy_d   = 1'b0;
          br_req_d = 1'b1;
          hold_d   = '0;
          state_d  = S_WAIT_AS;
        end else if (request_vme) begin
          br_req_d = 1'b1;
          state_d  = S_IDLE;
        end else if (tcnt_q == TIMEOUT_VAL) begin
          br_req_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT_AS: begin
        bbsy_d = 1'b0;
        hold_d = hold_inc;
        if (vme_as_in) begin
          acq_d   = 1'b0;
          state_d = S_OWNER;
        end
      end
      S_OWNER: begin
        bbsy_d = 1'b0;
        acq_d  = 1'b0;
        hold_d = hold_inc;
        if (release_ok) begin
          bbsy_d  = 1'b1;
          acq_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        br_req_d = 1'b1;
        bbsy_d   = 1'b1;
        acq_d    = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        br_req_d = 1'b1;
        bbsy_d   = 1'b1;
        acq_d    = 1'b1;
        tcnt_d   = '0;
        hold_d   = '0;
        pass_d   = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    br_d                = '1;
    br_d[REQUEST_LEVEL] = br_req_d;
    // Other levels are a one-cycle pass-through of the daisy chain.
    bg_d                = vme_bus_grant_in;
    bg_d[REQUEST_LEVEL] = ~pass_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      br_q      <= '1;
      bg_q      <= '1;
      bbsy_q    <= 1'b1;
      acq_q     <= 1'b1;
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
      hold_q    <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      br_q      <= br_d;
      bg_q      <= bg_d;
      bbsy_q    <= bbsy_d;
      acq_q     <= acq_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
      hold_q    <= hold_d;
      pass_q    <= pass_d;
    end
  end

  assign vme_bus_request   = br_q;
  assign vme_bus_grant_out = bg_q;
  assign vme_bbsy_out      = bbsy_q;
  assign bus_acquired      = acq_q;
  assign bus_timeout       = timeout_q;

endmodule

// File: tb/tb_vme_bus_requester.sv
// -----------------------------------------------------------------------------
// Testbench for vme_bus_requester. Two instances share one set of inputs: one
// in release-when-done mode, one in release-on-request mode, both requesting
// on level 3 with a 15-cycle grant timeout. A cycle-level behavioural model of
// each is checked against every output on every falling edge; directed
// literal checks pin the key latencies.
// -----------------------------------------------------------------------------
module tb_vme_bus_requester;

  localparam int LVL  = 3;
  localparam int GT   = 15;
  localparam int HOLD = 2;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_OWN  = 3;
  localparam int PH_REL  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       request_vme, transfer_busy;
  logic [3:0] br_in, bg_in;
  logic       bbsy_in, bclr_in, as_in;

  logic [3:0] r_br, r_bg, o_br, o_bg;
  logic       r_bbsy, r_acq, r_to, o_bbsy, o_acq, o_to;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  vme_bus_requester #(.NUM_LEVELS(4), .REQUEST_LEVEL(LVL), .RELEASE_MODE(0),
                      .GRANT_TIMEOUT(GT), .BBSY_MIN_CYCLES(HOLD)) u_rwd (
    .clock(clock), .reset(reset), .request_vme(request_vme),
    .transfer_busy(transfer_busy), .bus_acquired(r_acq), .bus_timeout(r_to),
    .vme_br_in(br_in), .vme_bus_request(r_br), .vme_bus_grant_in(bg_in),
    .vme_bus_grant_out(r_bg), .vme_bbsy_in(bbsy_in), .vme_bbsy_out(r_bbsy),
    .vme_bclr_in(bclr_in), .vme_as_in(as_in));

  vme_bus_requester #(.NUM_LEVELS(4), .REQUEST_LEVEL(LVL), .RELEASE_MODE(1),
                      .GRANT_TIMEOUT(GT), .BBSY_MIN_CYCLES(HOLD)) u_ror (
    .clock(clock), .reset(reset), .request_vme(request_vme),
    .transfer_busy(transfer_busy), .bus_acquired(o_acq), .bus_timeout(o_to),
    .vme_br_in(br_in), .vme_bus_request(o_br), .vme_bus_grant_in(bg_in),
    .vme_bus_grant_out(o_bg), .vme_bbsy_in(bbsy_in), .vme_bbsy_out(o_bbsy),
    .vme_bclr_in(bclr_in), .vme_as_in(as_in));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: tracks which phase of arbitration each requester is in
  // and when BR/BBSY went active; timeout and BBSY hold are elapsed-time tests.
  // ---------------------------------------------------------------------------
  typedef struct {
    int         ph;
    bit         pass;
    int         t_req;
    int         t_grant;
    logic [3:0] br;
    logic [3:0] bg;
    logic       bbsy;
    logic       acq;
    logic       to;
  } mdl_t;

  mdl_t m [2];
  int   cyc = 0;
  bit   model_ok = 0;
  bit   other;
  int   held;

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m[d].ph = PH_IDLE; m[d].pass = 0; m[d].t_req = 0; m[d].t_grant = 0;
        m[d].br = 4'hF; m[d].bg = 4'hF; m[d].bbsy = 1; m[d].acq = 1; m[d].to = 0;
      end
      model_ok = 1;
    end else begin
      cyc++;
      other = (br_in != 4'hF);
      for (int d = 0; d < 2; d++) begin
        m[d].to = 0;
        if (bg_in[LVL]) m[d].pass = 0;
        else if (m[d].ph == PH_IDLE) m[d].pass = 1;
        case (m[d].ph)
          PH_IDLE:
            if (!m[d].pass && !request_vme) begin
              m[d].ph = PH_REQ; m[d].t_req = cyc;
            end
          PH_REQ:
            if (!bg_in[LVL]) begin
              m[d].ph = PH_WAIT; m[d].t_grant = cyc;
            end else if (request_vme) begin
              m[d].ph = PH_IDLE;
            end else if (cyc - m[d].t_req == GT + 1) begin
              m[d].ph = PH_IDLE; m[d].to = 1;
            end
          PH_WAIT:
            if (as_in) m[d].ph = PH_OWN;
          PH_OWN: begin
            held = cyc - m[d].t_grant;
            if (held > HOLD && transfer_busy &&
                (!bclr_in || (request_vme && (d == 0 || other))))
              m[d].ph = PH_REL;
          end
          default: m[d].ph = PH_IDLE;
        endcase
        m[d].br      = 4'hF;
        m[d].br[LVL] = (m[d].ph != PH_REQ);
        m[d].bg      = bg_in;
        m[d].bg[LVL] = ~m[d].pass;
        m[d].bbsy    = !(m[d].ph == PH_WAIT || m[d].ph == PH_OWN);
        m[d].acq     = (m[d].ph != PH_OWN);
      end
    end
  end

  // One compare process, every falling edge, all outputs of both instances.
  initial forever begin
    @(negedge clock);
    if (model_ok) begin
      check("rwd_outputs", {r_br, r_bg, r_bbsy, r_acq, r_to},
            {m[0].br, m[0].bg, m[0].bbsy, m[0].acq, m[0].to});
      check("ror_outputs", {o_br, o_bg, o_bbsy, o_acq, o_to},
            {m[1].br, m[1].bg, m[1].bbsy, m[1].acq, m[1].to});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Inputs change 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  int n_low, n_bg3, n_park, n_pulse, first_to;

  initial begin
    reset = 1'b1; request_vme = 1'b1; transfer_busy = 1'b1;
    br_in = 4'hF; bg_in = 4'hF; bbsy_in = 1'b1; bclr_in = 1'b1; as_in = 1'b1;
    tick(3);
    check("reset_br", r_br, 4'hF);
    check("reset_bg", r_bg, 4'hF);
    check("reset_bbsy", r_bbsy, 1'b1);
    check("reset_acq", r_acq, 1'b1);
    check("reset_timeout", r_to, 1'b0);
    reset = 1'b0;
    tick(2);

    // Level 1 grant pass-through, 5 cycles, one cycle late.
    bg_in = 4'b1101;
    #1;
    check("bg1_delayed", r_bg[1], 1'b1);
    n_low = 0; n_bg3 = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (r_bg[1] == 1'b0) n_low++;
      if (r_bg[3] == 1'b0) n_bg3++;
      if (i == 4) bg_in[1] = 1'b1;
    end
    check("bg1_low_cycles", n_low, 5);
    check("bg3_untouched", n_bg3, 0);

    // RWD acquire / release.
    request_vme = 1'b0;
    tick(1);
    check("rwd_br_asserted", r_br, 4'b0111);
    check("ror_br_asserted", o_br, 4'b0111);
    bg_in[3] = 1'b0;
    tick(1);
    check("rwd_bbsy_after_grant", r_bbsy, 1'b0);
    check("rwd_acq_not_yet", r_acq, 1'b1);
    bg_in[3] = 1'b1;
    tick(1);
    check("rwd_acq_two_after_grant", r_acq, 1'b0);
    check("ror_acq_two_after_grant", o_acq, 1'b0);
    tick(3);
    request_vme = 1'b1;
    tick(1);
    check("rwd_release_bbsy", r_bbsy, 1'b1);
    check("rwd_release_acq", r_acq, 1'b1);
    check("ror_parked", o_acq, 1'b0);

    // ROR park for 100 cycles, then BCLR waits for the transfer to finish.
    n_park = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (o_acq == 1'b0 && o_bbsy == 1'b0) n_park++;
    end
    check("ror_park_cycles", n_park, 100);
    transfer_busy = 1'b0;
    bclr_in = 1'b0;
    tick(3);
    check("bclr_waits_transfer_bbsy", o_bbsy, 1'b0);
    check("bclr_waits_transfer_acq", o_acq, 1'b0);
    transfer_busy = 1'b1;
    tick(1);
    check("bclr_release_bbsy", o_bbsy, 1'b1);
    check("bclr_release_acq", o_acq, 1'b1);
    bclr_in = 1'b1;
    tick(2);

    // AS still held by the previous master.
    as_in = 1'b0;
    request_vme = 1'b0;
    tick(1);
    check("as_br_rwd", r_br, 4'b0111);
    check("as_br_ror", o_br, 4'b0111);
    bg_in[3] = 1'b0;
    tick(1);
    check("as_bbsy_rwd", r_bbsy, 1'b0);
    check("as_bbsy_ror", o_bbsy, 1'b0);
    bg_in[3] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("as_wait_acq_rwd", r_acq, 1'b1);
      check("as_wait_acq_ror", o_acq, 1'b1);
    end
    as_in = 1'b1;
    tick(1);
    check("as_free_acq_rwd", r_acq, 1'b0);
    check("as_free_acq_ror", o_acq, 1'b0);
    request_vme = 1'b1;
    tick(1);
    check("as_rwd_released", r_bbsy, 1'b1);
    check("as_ror_still_parked", o_acq, 1'b0);
    br_in[0] = 1'b0;
    tick(1);
    check("ror_release_on_br", o_bbsy, 1'b1);
    check("ror_release_on_br_acq", o_acq, 1'b1);
    br_in = 4'hF;
    tick(2);

    // Grant timeout: pulse 16 cycles after BR went active.
    request_vme = 1'b0;
    tick(1);
    check("to_br_asserted", r_br, 4'b0111);
    n_pulse = 0; first_to = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (r_to) begin
        n_pulse++;
        if (first_to < 0) first_to = k;
        check("to_br_released", r_br, 4'hF);
      end
      if (k == 16) request_vme = 1'b1;
    end
    check("to_pulse_count", n_pulse, 1);
    check("to_pulse_cycle", first_to, 16);
    bg_in[3] = 1'b0;
    tick(1);
    check("to_late_grant_passed", r_bg[3], 1'b0);
    check("to_late_grant_no_bbsy", r_bbsy, 1'b1);
    bg_in[3] = 1'b1;
    tick(1);
    check("to_late_grant_removed", r_bg[3], 1'b1);

    // Pass flag: an idle-time grant is passed on, not taken.
    bg_in[3] = 1'b0;
    tick(1);
    check("pass_bg3_low", r_bg[3], 1'b0);
    request_vme = 1'b0;
    tick(3);
    check("pass_no_br", r_br, 4'hF);
    check("pass_still_passing", r_bg[3], 1'b0);
    bg_in[3] = 1'b1;
    tick(1);
    check("pass_cleared_bg3", r_bg[3], 1'b1);
    check("pass_cleared_request", r_br, 4'b0111);
    bg_in[3] = 1'b0;
    tick(1);
    check("pass_then_grant_bbsy", r_bbsy, 1'b0);
    bg_in[3] = 1'b1;
    tick(1);
    check("owner_before_reset", r_acq, 1'b0);

    // Reset in OWNER releases immediately, with no clock edge in between.
    reset = 1'b1;
    #1;
    check("async_reset_bbsy_rwd", r_bbsy, 1'b1);
    check("async_reset_acq_rwd", r_acq, 1'b1);
    check("async_reset_bbsy_ror", o_bbsy, 1'b1);
    check("async_reset_acq_ror", o_acq, 1'b1);
    tick(2);
    reset = 1'b0;
    request_vme = 1'b1;
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vme_bus_requester.md
Name: vme_bus_requester

Overview:
- Parametrised VME bus requester replacing the bypassed single-level arbitration stage in the k30p VME interface.
- Requests the bus on a configurable level (BR0-BR3) and passes the bus grant daisy chain on every level.
- Drives BBSY and waits for the previous master's AS before reporting ownership to vme_data_transfer.
- Supports Release-When-Done and Release-On-Request modes, BCLR, and a grant timeout.

Parameters:
- NUM_LEVELS, 4, number of BR/BG level pairs.
- REQUEST_LEVEL, 3, level this board requests on (0..NUM_LEVELS-1).
- RELEASE_MODE, 0, 0 = RWD (release when done), 1 = ROR (release on request).
- GRANT_TIMEOUT, 1023, cycles in REQUEST before giving up; width = clog2(GRANT_TIMEOUT+1).
- BBSY_MIN_CYCLES, 2, minimum cycles bbsy_out is held active.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- request_vme  in  1  active-low, CPU wants the VME bus
- transfer_busy  in  1  active-low, vme_data_transfer is mid-cycle
- bus_acquired  out  1  active-low, bus owned and AS free
- bus_timeout  out  1  active-high, one-cycle pulse on grant timeout
- vme_br_in  in  NUM_LEVELS  active-low, sampled BR lines (wired-OR bus)
- vme_bus_request  out  NUM_LEVELS  active-low BR drivers
- vme_bus_grant_in  in  NUM_LEVELS  active-low BGxIN
- vme_bus_grant_out  out  NUM_LEVELS  active-low BGxOUT
- vme_bbsy_in  in  1  active-low, sampled BBSY
- vme_bbsy_out  out  1  active-low BBSY driver
- vme_bclr_in  in  1  active-low bus clear from the arbiter
- vme_as_in  in  1  active-low, sampled bus AS

Behaviour:
- All outputs are registered on posedge clock.
- Reset, asynchronous: state IDLE; vme_bus_request, vme_bus_grant_out, vme_bbsy_out and bus_acquired all 1; bus_timeout 0; counters 0; pass flag clear.
- Reset during ownership releases BBSY immediately.
- Levels other than REQUEST_LEVEL:
  - vme_bus_grant_out[i] equals vme_bus_grant_in[i], one cycle later.
  - vme_bus_request[i] is held at 1.
- REQUEST_LEVEL grant, pass flag:
  - Set when grant_in goes active while the state is IDLE.
  - While the flag is set, grant_out follows grant_in and the grant is never taken, even if request_vme asserts.
  - Cleared when grant_in goes inactive.
  - Otherwise grant_out = 1.
- IDLE:
  - If request_vme=0 and the pass flag is clear: drive BR active, clear the timeout counter, go to REQUEST.
- REQUEST:
  - BR is held active and the counter increments.
  - If grant_in=0: assert vme_bbsy_out, deassert BR, clear the BBSY hold counter, go to WAIT_AS.
  - Else if request_vme=1: deassert BR, go to IDLE (request withdrawn).
  - Else if counter = GRANT_TIMEOUT: deassert BR, pulse bus_timeout for 1 cycle, go to IDLE.
  - Grant and timeout in the same cycle: the grant wins.
- WAIT_AS:
  - Hold BBSY.
  - When vme_as_in=1: bus_acquired=0, go to OWNER.
  - Minimum latency from grant to bus_acquired is 2 cycles.
- OWNER:
  - Hold BBSY and bus_acquired; the BBSY hold counter saturates at BBSY_MIN_CYCLES.
  - Release requires all of: hold counter ≥ BBSY_MIN_CYCLES, transfer_busy=1, and one of the mode conditions below.
  - RWD mode: request_vme=1.
  - ROR mode: request_vme=1 and (any vme_br_in=0 or vme_bclr_in=0).
  - In ROR, with request_vme=1 and no other requester, the bus stays parked (bus_acquired stays 0).
  - On release: vme_bbsy_out=1, bus_acquired=1, go to RELEASE.
  - BCLR never aborts an in-progress transfer; it only forces release at the next idle point, regardless of mode.
- RELEASE:
  - One cycle, then IDLE.
  - If request_vme=0 here, it is re-requested from IDLE on the next cycle (no back-to-back reuse without arbitration).
- Illegal state code: go to IDLE with all outputs inactive.

Test Plan:
- Levels, pass-through: REQUEST_LEVEL=3; pulse grant_in[1]=0 for 5 cycles while IDLE -> grant_out[1]=0 for exactly 5 cycles, 1 cycle delayed; grant_out[3] stays 1.
- RWD acquire/release: request_vme=0 -> BR[3]=0 next cycle; grant_in[3]=0 with vme_as_in=1 -> bbsy_out=0 next cycle, bus_acquired=0 2 cycles after grant; request_vme=1, transfer_busy=1 -> bbsy_out=1 and bus_acquired=1 after 1 cycle.
- AS wait: grant while vme_as_in=0 for 6 cycles -> bus_acquired stays 1 until the cycle after AS rises.
- ROR park and BCLR: RELEASE_MODE=1; request_vme=1 with no BR active -> bus stays held 100 cycles; assert vme_bclr_in=0 while transfer_busy=0 -> no release until transfer_busy=1, then bbsy_out=1 next cycle.
- Timeout: GRANT_TIMEOUT=15, request held, no grant -> bus_timeout=1 for exactly 1 cycle, 16 cycles after BR asserts; BR=1 the same cycle; a later grant_in[3]=0 is passed to grant_out[3].
- Pass flag and reset: grant_in[3]=0 while IDLE, then request_vme=0 -> BR stays 1 and grant is passed until grant_in=1; assert reset in OWNER -> bbsy_out and bus_acquired are 1 immediately, without waiting for a clock edge.
